// File: rtl/sample_dispatch_pkg.sv
// Shared definitions for the EBI-mapped sample dispatch block.
// Contents: register offsets, CONTROL/STATUS bit positions, FIFO entry
// layout, FSM state encoding and a target-to-one-hot helper.
package sample_dispatch_pkg;

    // EBI register offsets (addr[7:0])
    localparam logic [7:0] OFS_TARGET  = 8'h00;
    localparam logic [7:0] OFS_DATA    = 8'h01;
    localparam logic [7:0] OFS_CONTROL = 8'h02;

    // CONTROL write bits
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_ERR = 2;

    // STATUS read bits; count occupies [STAT_COUNT_MSB:0]
    localparam int STAT_OVERFLOW  = 15;
    localparam int STAT_TIMEOUT   = 14;
    localparam int STAT_BUSY      = 13;
    localparam int STAT_FULL      = 12;
    localparam int STAT_EMPTY     = 11;
    localparam int STAT_COUNT_MSB = 8;
    localparam int STAT_COUNT_W   = STAT_COUNT_MSB + 1;

    // FIFO entry layout: {target, sample}
    localparam int TARGET_W = 6;
    localparam int SAMPLE_W = 16;
    localparam int ENTRY_W  = TARGET_W + SAMPLE_W;

    typedef struct packed {
        logic [TARGET_W-1:0] target;
        logic [SAMPLE_W-1:0] sample;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_LOAD     = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    function automatic logic [63:0] target_onehot(input logic [TARGET_W-1:0] t);
        return 64'd1 << t;
    endfunction

endpackage

// File: rtl/sample_dispatch_if.sv
// EBI bus seen by an EBI-mapped block.
// Signals: addr (19b address), ebi_data_in (write data), ebi_data_out
// (registered read data), enable (chip enable), re / wr (strobes).
// Modports: master = EBI host, slave = mapped block.
interface sample_dispatch_if;

    logic [18:0] addr;
    logic [15:0] ebi_data_in;
    logic [15:0] ebi_data_out;
    logic        enable;
    logic        re;
    logic        wr;

    modport master (
        output addr, ebi_data_in, enable, re, wr,
        input  ebi_data_out
    );

    modport slave (
        input  addr, ebi_data_in, enable, re, wr,
        output ebi_data_out
    );

endinterface

// File: rtl/sample_dispatch_dp_ram.sv
// dp_ram: simple dual-port RAM, no reset on storage.
// Ports: clk; port A write (we_a, addr_a, din_a); port B registered read
// (en_b, addr_b, dout_b -- dout_b updates on the edge where en_b is high).
module dp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 22
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              en_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] dout_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    always_ff @(posedge clk) begin
        if (en_b) begin
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/sample_dispatch.sv
// sample_dispatch: EBI-mapped FIFO that forwards {target, sample} entries
// to one of 64 controllers with a one-hot enable / ack handshake.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   ebi                 EBI slave (addr, ebi_data_in, ebi_data_out, enable, re, wr)
//   controller_enable   one-hot select of the target controller (or zero)
//   ctrl_data           sample word presented to the selected controller
//   ctrl_ack            controller has consumed ctrl_data
module sample_dispatch
    import sample_dispatch_pkg::*;
#(
    parameter int POSITION   = 0,
    parameter int DEPTH_LOG2 = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    sample_dispatch_if.slave ebi,
    output logic [63:0]      controller_enable,
    output logic [15:0]      ctrl_data,
    input  logic             ctrl_ack
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                state;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [TARGET_W-1:0]   target;
    logic                  run;
    logic                  overflow;
    logic                  timeout;
    logic                  wr_q;

    logic                  sel;
    logic [7:0]            offset;
    logic                  wr_evt;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  ctl_wr;
    logic                  flush;
    logic                  clr_err;
    logic                  empty;
    logic                  full;
    logic                  busy;
    logic                  overflow_evt;
    logic                  timeout_evt;
    logic [ENTRY_W-1:0]    rd_word;
    entry_t                rd_entry;
    logic [15:0]           status;

    assign sel    = ebi.enable && (ebi.addr[18:8] == 11'(POSITION));
    assign offset = ebi.addr[7:0];

    // A write acts once, on the cycle wr rises while selected.
    assign wr_evt   = sel && ebi.wr && !wr_q;
    assign push_req = wr_evt && (offset == OFS_DATA);
    assign ctl_wr   = wr_evt && (offset == OFS_CONTROL);
    assign flush    = ctl_wr && ebi.ebi_data_in[CTRL_FLUSH];
    assign clr_err  = ctl_wr && ebi.ebi_data_in[CTRL_CLR_ERR];

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign busy  = (state != S_IDLE);
    assign pop   = (state == S_FETCH);

    assign push_ok      = push_req && !full && !flush;
    assign overflow_evt = push_req && full;
    assign timeout_evt  = (state == S_WAIT_ACK) && !ctrl_ack
                          && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    assign rd_entry = entry_t'(rd_word);

    always_comb begin
        status                   = '0;
        status[STAT_OVERFLOW]    = overflow;
        status[STAT_TIMEOUT]     = timeout;
        status[STAT_BUSY]        = busy;
        status[STAT_FULL]        = full;
        status[STAT_EMPTY]       = empty;
        status[STAT_COUNT_MSB:0] = STAT_COUNT_W'(count);
    end

    dp_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk    (clk),
        .we_a   (push_ok),
        .addr_a (wr_ptr),
        .din_a  ({target, ebi.ebi_data_in}),
        .en_b   (pop),
        .addr_b (rd_ptr),
        .dout_b (rd_word)
    );

    // EBI register file and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q             <= 1'b0;
            run              <= 1'b0;
            target           <= '0;
            overflow         <= 1'b0;
            timeout          <= 1'b0;
            ebi.ebi_data_out <= '0;
        end else begin
            wr_q <= ebi.wr;
            if (wr_evt && (offset == OFS_TARGET)) begin
                target <= ebi.ebi_data_in[TARGET_W-1:0];
            end
            if (ctl_wr) begin
                run <= ebi.ebi_data_in[CTRL_RUN];
            end
            // a same-cycle error event wins over clear
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (timeout_evt) begin
                timeout <= 1'b1;
            end else if (clr_err) begin
                timeout <= 1'b0;
            end
            if (sel && ebi.re) begin
                ebi.ebi_data_out <= (offset == OFS_CONTROL) ? status : '0;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Dispatch FSM with registered controller outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            controller_enable <= '0;
            ctrl_data         <= '0;
            wait_cnt          <= '0;
        end else if (flush) begin
            state             <= S_IDLE;
            controller_enable <= '0;
            wait_cnt          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run && !empty) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    ctrl_data         <= rd_entry.sample;
                    controller_enable <= target_onehot(rd_entry.target);
                    wait_cnt          <= '0;
                    state             <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ctrl_ack) begin
                        controller_enable <= '0;
                        state             <= (run && !empty) ? S_FETCH : S_IDLE;
                    end else if (timeout_evt) begin
                        controller_enable <= '0;
                        state             <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state             <= S_IDLE;
                    controller_enable <= '0;
                end
            endcase
        end
    end

endmodule
